// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Default timing assumes a 100 MHz system clock.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;

    // Smallest width w >= 1 with 2**w >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned w;
        w = 1;
        while (w < 32 && (32'd1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: synchroniser, stability filter, edge pulses
// and optional auto-repeat of the press pulse.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic rise_next
);

    localparam int unsigned CW   = clog2(STABLE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                   REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = clog2(RMAX);

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    rpt_state_e             state_q, state_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   deb_rise, deb_fall, rep_fire;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        sync   = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        deb_rise = 1'b0;
        deb_fall = 1'b0;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d  = sync;
            cnt_d    = '0;
            deb_rise = sync;
            deb_fall = ~sync;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rep_fire = 1'b0;
        unique case (state_q)
            RPT_IDLE: begin
                if (deb_rise) begin
                    state_d = RPT_DELAY;
                    rcnt_d  = '0;
                end
            end
            RPT_DELAY: begin
                if (rcnt_q == DLY_LAST) begin
                    rep_fire = 1'b1;
                    rcnt_d   = '0;
                    state_d  = RPT_REPEAT;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            RPT_REPEAT: begin
                if (rcnt_q == PER_LAST) begin
                    rep_fire = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            default: begin
                state_d = RPT_IDLE;
                rcnt_d  = '0;
            end
        endcase
        // A release wins over any repeat due in the same cycle.
        if (deb_fall || !REPEAT_EN) begin
            state_d  = RPT_IDLE;
            rcnt_d   = '0;
            rep_fire = 1'b0;
        end
        rise_d = deb_rise | rep_fire;
        fall_d = deb_fall;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            state_q <= RPT_IDLE;
            rcnt_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_next  = rise_d;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner; any_press is registered from
// the channels' next-cycle press so it lines up with rise_pulse.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned CH            = 5,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] din,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse,
    output logic          any_press
);

    logic [CH-1:0] rise_next;
    logic          any_press_q, any_press_d;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .din       (din[i]),
            .level     (level[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
            .rise_next (rise_next[i])
        );
    end

    always_comb begin
        any_press_d = |rise_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (repeat off/on) checked
// every cycle against a window-based reference model.
module tb_button_conditioner;

    localparam int CH     = 2;
    localparam int STABLE = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] din = 2'b00;
    logic [1:0] lvl0, rise0, fall0, lvl1, rise1, fall1;
    logic       any0, any1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .CH(2), .SYNC_STAGES(2), .STABLE_CYCLES(STABLE), .REPEAT_EN(1'b0),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut0 (
        .clk(clk), .rst(rst), .din(din), .level(lvl0),
        .rise_pulse(rise0), .fall_pulse(fall0), .any_press(any0)
    );

    button_conditioner #(
        .CH(2), .SYNC_STAGES(2), .STABLE_CYCLES(STABLE), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut1 (
        .clk(clk), .rst(rst), .din(din), .level(lvl1),
        .rise_pulse(rise1), .fall_pulse(fall1), .any_press(any1)
    );

    // Reference model: the level flips once the last STABLE synchronised
    // samples, all taken since the previous flip or reset, disagree with it.
    int         cyc = 100;
    bit         p0[2], p1[2];
    bit         hist[2][64];
    int         lastchg[2];
    int         rise_at[2];
    logic [1:0] m_lv = 2'b00, m_r0 = 2'b00, m_r1 = 2'b00, m_f = 2'b00;

    wire [13:0] obs  = {lvl0, rise0, fall0, any0, lvl1, rise1, fall1, any1};
    wire [13:0] expv = {m_lv, m_r0, m_f, |m_r0, m_lv, m_r1, m_f, |m_r1};

    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < CH; c++) begin
            bit s;
            bit chg;
            bit rep;
            int d;
            if (!rst) begin
                p0[c] = 1'b0; p1[c] = 1'b0;
                m_lv[c] = 1'b0; m_r0[c] = 1'b0; m_r1[c] = 1'b0; m_f[c] = 1'b0;
                lastchg[c] = cyc;
                rise_at[c] = -1;
            end else begin
                s = p1[c];
                p1[c] = p0[c];
                p0[c] = din[c];
                hist[c][cyc % 64] = s;
                chg = (cyc - lastchg[c] >= STABLE);
                for (int j = 0; j < STABLE; j++)
                    if (hist[c][(cyc - j) % 64] == m_lv[c]) chg = 1'b0;
                rep = 1'b0;
                d = cyc - rise_at[c];
                if (chg) begin
                    m_lv[c] = s;
                    lastchg[c] = cyc;
                    rise_at[c] = s ? cyc : -1;
                end else if (rise_at[c] >= 0) begin
                    rep = (d == DELAY) || (d > DELAY && (d - DELAY) % PERIOD == 0);
                end
                m_r0[c] = chg & s;
                m_r1[c] = (chg & s) | rep;
                m_f[c]  = chg & ~s;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int t_lvl = -1;
        int n_any = 0;
        rst = 1'b0;
        din = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== 14'd0) begin
                errors++;
                $display("FAIL reset_zero cyc=%0d got=%b exp=0", cyc, obs);
            end
        end
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (lvl0 == 2'b11 && t_lvl < 0) t_lvl = i;
            if (any0) n_any++;
        end
        checks++;
        if (t_lvl !== 6) begin
            errors++;
            $display("FAIL reset_latency got=%0d exp=6", t_lvl);
        end
        checks++;
        if (n_any !== 1) begin
            errors++;
            $display("FAIL reset_any_press got=%0d exp=1", n_any);
        end
        din = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_clean_press();
        int t_r = -1;
        int t_f = -1;
        int n_r = 0;
        din[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL press_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (rise0[0]) begin
                n_r++;
                if (t_r < 0) t_r = i;
            end
        end
        checks++;
        if (t_r !== 6 || n_r !== 1) begin
            errors++;
            $display("FAIL press_timing got=t%0d/n%0d exp=t6/n1", t_r, n_r);
        end
        din[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL release_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (fall0[0] && t_f < 0) t_f = i;
        end
        checks++;
        if (t_f !== 6) begin
            errors++;
            $display("FAIL release_timing got=%0d exp=6", t_f);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] seq = 5'b10101;
        int         t_r = -1;
        int         n_r = 0;
        int         n_f = 0;
        int         n_tr = 0;
        logic       prev = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            din[0] = (i <= 5) ? seq[i-1] : 1'b1;
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (rise0[0]) begin
                n_r++;
                if (t_r < 0) t_r = i;
            end
            if (fall0[0]) n_f++;
            if (lvl0[0] !== prev) n_tr++;
            prev = lvl0[0];
        end
        checks++;
        if (t_r !== 10 || n_r !== 1 || n_f !== 0 || n_tr !== 1) begin
            errors++;
            $display("FAIL bounce_pulses got=t%0d/r%0d/f%0d/tr%0d exp=t10/r1/f0/tr1",
                     t_r, n_r, n_f, n_tr);
        end
        din[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL bounce_release cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_sub_threshold();
        int seen = 0;
        for (int i = 0; i < 13; i++) begin
            din[0] = (i < 3);
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL glitch_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (lvl0[0] || rise0[0] || fall0[0] || lvl1[0]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL glitch_quiet got=%0d exp=0", seen);
        end
    endtask

    task automatic test_auto_repeat();
        int offs[$];
        int expo[7] = '{10, 13, 16, 19, 22, 25, 28};
        int found = 0;
        int n_f = 0;
        int late_r = 0;
        bit fell = 0;
        din[1] = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL repeat_wait cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (rise1[1]) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL repeat_rise_timeout got=none exp=rise");
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL repeat_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (rise1[1]) offs.push_back(k);
        end
        checks++;
        if (offs.size() != 7) begin
            errors++;
            $display("FAIL repeat_count got=%0d exp=7", offs.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (offs[k] !== expo[k]) begin
                    errors++;
                    $display("FAIL repeat_offset got=%0d exp=%0d", offs[k], expo[k]);
                end
            end
        end
        din[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL repeat_release cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (fell && rise1[1]) late_r++;
            if (fall1[1]) begin
                n_f++;
                fell = 1;
            end
        end
        checks++;
        if (n_f !== 1 || late_r !== 0) begin
            errors++;
            $display("FAIL repeat_stop got=f%0d/r%0d exp=f1/r0", n_f, late_r);
        end
    endtask

    task automatic test_back_to_back();
        int found = 0;
        int n_any = 0;
        int t_r = -1;
        int t_rep = -1;
        din = 2'b11;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL simul_wait cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (rise0 != 2'b00) begin
                found = 1;
                checks++;
                if (rise0 !== 2'b11 || rise1 !== 2'b11 || any0 !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_pulses got=%b/%b/%b exp=11/11/1",
                             rise0, rise1, any0);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL simul_timeout got=none exp=rise");
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL simul_hold cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (any0) n_any++;
        end
        checks++;
        if (n_any !== 0) begin
            errors++;
            $display("FAIL simul_any_single got=%0d exp=0", n_any);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL midrep_reset cyc=%0d got=%b exp=0", cyc, obs);
        end
        rst = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL midrep_restart cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
            if (rise1[1] && t_r < 0) t_r = i;
            else if (rise1[1] && t_r >= 0 && t_rep < 0) t_rep = i - t_r;
        end
        checks++;
        if (t_r !== 6 || t_rep !== DELAY) begin
            errors++;
            $display("FAIL midrep_sequence got=t%0d/d%0d exp=t6/d%0d", t_r, t_rep, DELAY);
        end
        din = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL midrep_release cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        int hold[2] = '{0, 0};
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    din[c] = ~din[c];
                    hold[c] = (i % 97 < 40) ? $urandom_range(1, 3) : $urandom_range(1, 25);
                end
                hold[c]--;
            end
            rst = ($urandom_range(0, 149) != 0);
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, expv);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sub_threshold();
        test_auto_repeat();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
